// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and small helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  // MULT/MULTU/DIV/DIVU occupy encodings 0..3; bit 0 marks the unsigned form.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, subtract-restore for divide.
// acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Both candidate iterations are formed; is_div picks one.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, operand};
    if (is_div) begin
      if (diff[WIDTH] == 1'b0) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/DIV unit with architectural HI/LO registers, MTHI/MTLO
// writes and a combinational MFHI/MFLO read port.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             rd_hi_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opnd, a_orig, hi, lo, res_hi, res_lo, a_mag, b_mag, quo, rem;
  logic               is_div, neg_res, neg_rem, div_zero, done;
  logic               op_signed, accept, mt_hi, mt_lo, wr_result;

  assign op_signed = ~op_i[0];
  assign a_mag     = (op_signed && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_mag     = (op_signed && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
  assign accept    = (state == ST_IDLE) && start_i && !flush_i && is_muldiv(op_i);
  assign mt_hi     = (state == ST_IDLE) && start_i && !flush_i && (op_i == OP_MTHI);
  assign mt_lo     = (state == ST_IDLE) && start_i && !flush_i && (op_i == OP_MTLO);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_step)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = accept ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (flush_i) begin
          state_next = ST_IDLE;
        end else if (cnt == CW'(WIDTH - 1)) begin
          state_next = ST_FIX;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o    = (state != ST_IDLE);
    wr_result = (state == ST_FIX) && !flush_i;
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    prod = neg_res ? (~acc + 1'b1) : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_orig;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = neg_rem ? (~rem + 1'b1) : rem;
      res_lo = neg_res ? (~quo + 1'b1) : quo;
    end
  end

  // Iteration datapath: operand latch, accumulator and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      acc      <= {{WIDTH{1'b0}}, a_mag};
      opnd     <= b_mag;
      a_orig   <= a_i;
      is_div   <= op_i[1];
      neg_res  <= op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem  <= op_signed && a_i[WIDTH-1];
      div_zero <= (b_i == {WIDTH{1'b0}});
    end else if (state == ST_RUN) begin
      cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
      acc <= acc_step;
    end else begin
      cnt <= cnt;
      acc <= acc;
    end
  end

  // Architectural HI/LO and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= wr_result;
      if (wr_result) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_hi) begin
        hi <= a_i;
      end else if (mt_lo) begin
        lo <= a_i;
      end else begin
        hi <= hi;
        lo <= lo;
      end
    end
  end

  assign hi_o      = hi;
  assign lo_o      = lo;
  assign done_o    = done;
  assign rd_data_o = rd_hi_i ? hi : lo;

endmodule
